// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I sequencer: FSM states, opcode values,
// datapath select encodings and the instruction-class decode.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    SRC_A_PC   = 2'd0,
    SRC_A_RS1  = 2'd1,
    SRC_A_ZERO = 2'd2
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } src_b_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_FUNCT = 2'd1,
    ALU_BR    = 2'd2
  } alu_op_e;

  typedef enum logic [3:0] {
    C_R, C_I_ALU, C_LUI, C_AUIPC, C_LOAD, C_STORE,
    C_BRANCH, C_JAL, C_JALR, C_ECALL, C_UNK
  } cls_e;

  typedef struct packed {
    logic    pc_write;
    logic    pc_source;
    logic    ir_write;
    logic    i_or_d;
    logic    mem_read;
    logic    mem_write;
    logic    mdr_write;
    logic    reg_write;
    wb_sel_e wb_sel;
    src_a_e  alu_src_a;
    src_b_e  alu_src_b;
    alu_op_e alu_ctrl_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic cls_e decode_cls(input logic [6:0] op);
    cls_e cls;
    case (op)
      OP_R:      cls = C_R;
      OP_I_ALU:  cls = C_I_ALU;
      OP_LUI:    cls = C_LUI;
      OP_AUIPC:  cls = C_AUIPC;
      OP_LOAD:   cls = C_LOAD;
      OP_STORE:  cls = C_STORE;
      OP_BRANCH: cls = C_BRANCH;
      OP_JAL:    cls = C_JAL;
      OP_JALR:   cls = C_JALR;
      OP_SYSTEM: cls = C_ECALL;
      default:   cls = C_UNK;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_perf_counter.sv
// Cycle and retired-instruction counters for mc_control_fsm; only built when
// PERF_CNT_EN is defined. Both wrap modulo 2^CNT_W.
module mc_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cycle_inc,
  input  logic             i_retire_inc,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_retired_count
);

  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_retired;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle   <= '0;
      r_retired <= '0;
    end else begin
      if (i_cycle_inc)  r_cycle   <= r_cycle + CNT_W'(1);
      if (i_retire_inc) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign o_cycle_count   = r_cycle;
  assign o_retired_count = r_retired;

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I sequencer: steps IF/ID/EX/MEM/WB, stalls on memory ready and
// halts on ECALL. Define PERF_CNT_EN to build the cycle/retired counters.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             bcond,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_source,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mdr_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_ctrl_op,
  output logic             is_halted,
  output logic [2:0]       state_dbg,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  state_e r_state;
  state_e w_next;
  cls_e   r_cls;
  cls_e   w_id_cls;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;

  // The opcode is decoded once in ID; later states work from the latched class.
  assign w_id_cls = decode_cls(opcode);

  // NOTE: state flops use non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IF;
      r_cls   <= C_UNK;
    end else begin
      r_state <= w_next;
      if (r_state == S_ID) r_cls <= w_id_cls;
    end
  end

  // NOTE: next state and every control field get a default first, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    w_ctrl = CTRL_IDLE;
    case (r_state)
      S_IF: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_a = SRC_A_PC;
        w_ctrl.alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_next          = S_ID;
        end
      end
      S_ID: begin
        // old_pc + imm lands in ALUOut for branch/JAL targets and AUIPC.
        w_ctrl.alu_src_a = SRC_A_PC;
        w_ctrl.alu_src_b = SRC_B_IMM;
        case (w_id_cls)
          C_ECALL: w_next = S_HALT;
          C_AUIPC: w_next = S_WB;
          C_UNK:   w_next = S_IF;
          default: w_next = S_EX;
        endcase
      end
      S_EX: begin
        w_next = S_IF;
        case (r_cls)
          C_R: begin
            w_ctrl.alu_src_a   = SRC_A_RS1;
            w_ctrl.alu_src_b   = SRC_B_RS2;
            w_ctrl.alu_ctrl_op = ALU_FUNCT;
            w_next             = S_WB;
          end
          C_I_ALU: begin
            w_ctrl.alu_src_a   = SRC_A_RS1;
            w_ctrl.alu_src_b   = SRC_B_IMM;
            w_ctrl.alu_ctrl_op = ALU_FUNCT;
            w_next             = S_WB;
          end
          C_LUI: begin
            w_ctrl.alu_src_a = SRC_A_ZERO;
            w_ctrl.alu_src_b = SRC_B_IMM;
            w_next           = S_WB;
          end
          C_LOAD, C_STORE: begin
            w_ctrl.alu_src_a = SRC_A_RS1;
            w_ctrl.alu_src_b = SRC_B_IMM;
            w_next           = S_MEM;
          end
          C_BRANCH: begin
            w_ctrl.alu_src_a   = SRC_A_RS1;
            w_ctrl.alu_src_b   = SRC_B_RS2;
            w_ctrl.alu_ctrl_op = ALU_BR;
            if (bcond) begin
              w_ctrl.pc_write  = 1'b1;
              w_ctrl.pc_source = 1'b1;
            end
          end
          C_JAL: begin
            // PC already holds old_pc + 4, which is the link value.
            w_ctrl.reg_write = 1'b1;
            w_ctrl.wb_sel    = WB_PC;
            w_ctrl.pc_write  = 1'b1;
            w_ctrl.pc_source = 1'b1;
          end
          C_JALR: begin
            // Link and jump share one edge; both read pre-edge values, so rd == rs1 is safe.
            w_ctrl.alu_src_a = SRC_A_RS1;
            w_ctrl.alu_src_b = SRC_B_IMM;
            w_ctrl.reg_write = 1'b1;
            w_ctrl.wb_sel    = WB_PC;
            w_ctrl.pc_write  = 1'b1;
            w_ctrl.pc_source = 1'b0;
          end
          default: w_next = S_IF;
        endcase
      end
      S_MEM: begin
        w_ctrl.i_or_d = 1'b1;
        if (r_cls == C_LOAD) begin
          w_ctrl.mem_read = 1'b1;
          if (mem_ready) begin
            w_ctrl.mdr_write = 1'b1;
            w_next           = S_WB;
          end
        end else begin
          w_ctrl.mem_write = 1'b1;
          if (mem_ready) w_next = S_IF;
        end
      end
      S_WB: begin
        w_ctrl.reg_write = 1'b1;
        if (r_cls == C_LOAD) w_ctrl.wb_sel = WB_MDR;
        else                 w_ctrl.wb_sel = WB_ALUOUT;
        w_next = S_IF;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  // Holding reset low silences every strobe at once, so an abandoned store never writes.
  assign w_out = reset ? w_ctrl : CTRL_IDLE;

  assign pc_write    = w_out.pc_write;
  assign pc_source   = w_out.pc_source;
  assign ir_write    = w_out.ir_write;
  assign i_or_d      = w_out.i_or_d;
  assign mem_read    = w_out.mem_read;
  assign mem_write   = w_out.mem_write;
  assign mdr_write   = w_out.mdr_write;
  assign reg_write   = w_out.reg_write;
  assign wb_sel      = w_out.wb_sel;
  assign alu_src_a   = w_out.alu_src_a;
  assign alu_src_b   = w_out.alu_src_b;
  assign alu_ctrl_op = w_out.alu_ctrl_op;
  assign is_halted   = (r_state == S_HALT);
  assign state_dbg   = r_state;

`ifdef PERF_CNT_EN
  logic w_cycle_inc;
  logic w_retire;

  assign w_cycle_inc = (r_state != S_HALT);
  // Retire on the final step back to IF, or on ID -> HALT for ECALL.
  assign w_retire = ((r_state != S_IF) && (r_state != S_HALT) && (w_next == S_IF)) ||
                    ((r_state == S_ID) && (w_next == S_HALT));

  mc_perf_counter #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk             (clk),
    .reset           (reset),
    .i_cycle_inc     (w_cycle_inc),
    .i_retire_inc    (w_retire),
    .o_cycle_count   (cycle_count),
    .o_retired_count (retired_count)
  );
`else
  assign cycle_count   = '0;
  assign retired_count = '0;
`endif

endmodule
